// File: rtl/rect_mover.sv
// rect_mover: per-frame rectangle motion engine for the VGA display path.
//
// Moves a W x H rectangle by `speed` pixels on each frame_tick (when move is
// set) in one of four modes: RASTER wrap-around, BOUNCE, MANUAL button
// steering or HOLD. All outputs are registered from the same next-state.
//
// Ports:
//   clk         pixel/system clock
//   rst         synchronous active-high reset
//   frame_tick  one-cycle pulse per frame, the only update instant
//   move        motion enable, sampled with frame_tick
//   mode        00 RASTER, 01 BOUNCE, 10 MANUAL, 11 HOLD
//   speed       pixels per update (0 = no motion)
//   btn_*       MANUAL steering levels
//   borde_izq   left edge x          borde_der   right edge x+W-1
//   borde_up    top edge y           borde_down  bottom edge y+H-1
//   edge_hit    {top,bottom,left,right} contact pulse
//   wrap        RASTER line/frame wrap pulse
module rect_mover #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned W       = 100,
    parameter int unsigned H       = 50,
    parameter int unsigned X0      = 0,
    parameter int unsigned Y0      = 100,
    parameter int unsigned COORD_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               move,
    input  logic [1:0]         mode,
    input  logic [3:0]         speed,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [COORD_W-1:0] borde_izq,
    output logic [COORD_W-1:0] borde_der,
    output logic [COORD_W-1:0] borde_up,
    output logic [COORD_W-1:0] borde_down,
    output logic [3:0]         edge_hit,
    output logic               wrap
);

    localparam int unsigned CW1 = COORD_W + 1;

    localparam logic [COORD_W:0]   XMAX   = CW1'(H_RES - W);
    localparam logic [COORD_W:0]   YMAX   = CW1'(V_RES - H);
    localparam logic [COORD_W-1:0] XSTART = COORD_W'(X0);
    localparam logic [COORD_W-1:0] YSTART = COORD_W'(Y0);
    localparam logic [COORD_W-1:0] WM1    = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] HM1    = COORD_W'(H - 1);

    localparam logic [1:0] ModeRaster = 2'b00;
    localparam logic [1:0] ModeBounce = 2'b01;
    localparam logic [1:0] ModeManual = 2'b10;
    localparam logic [1:0] ModeHold   = 2'b11;

    // edge_hit bit positions
    localparam int unsigned HitTop    = 3;
    localparam int unsigned HitBottom = 2;
    localparam int unsigned HitLeft   = 1;
    localparam int unsigned HitRight  = 0;

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [COORD_W-1:0] der_q, down_q;
    logic [3:0]         hit_q, hit_d;
    logic               wrap_q, wrap_d;

    logic [COORD_W:0]   x_inc, y_inc, spd_w;
    logic [COORD_W-1:0] x_dec, y_dec;
    logic               x_floor, y_floor;   // a decrement would reach or pass 0

    always_comb begin
        spd_w   = CW1'(speed);
        x_inc   = {1'b0, x_q} + spd_w;
        y_inc   = {1'b0, y_q} + spd_w;
        x_dec   = x_q - COORD_W'(speed);
        y_dec   = y_q - COORD_W'(speed);
        x_floor = ({1'b0, x_q} <= spd_w);
        y_floor = ({1'b0, y_q} <= spd_w);

        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        hit_d   = 4'b0000;
        wrap_d  = 1'b0;

        if (frame_tick && move) begin
            unique case (mode)
                ModeRaster: begin
                    if (x_inc <= XMAX) begin
                        x_d = x_inc[COORD_W-1:0];
                    end else begin
                        wrap_d = 1'b1;
                        if (y_inc <= YMAX) begin
                            x_d = '0;
                            y_d = y_inc[COORD_W-1:0];
                        end else begin
                            x_d = XSTART;
                            y_d = YSTART;
                        end
                    end
                end

                ModeBounce: begin
                    // Speed 0 must not re-trigger a bounce while parked on a bound.
                    if (speed != 4'd0) begin
                        if (dir_x_q) begin
                            if (x_inc >= XMAX) begin
                                x_d               = XMAX[COORD_W-1:0];
                                dir_x_d           = 1'b0;
                                hit_d[HitRight]   = 1'b1;
                            end else begin
                                x_d = x_inc[COORD_W-1:0];
                            end
                        end else if (x_floor) begin
                            x_d             = '0;
                            dir_x_d         = 1'b1;
                            hit_d[HitLeft]  = 1'b1;
                        end else begin
                            x_d = x_dec;
                        end

                        if (dir_y_q) begin
                            if (y_inc >= YMAX) begin
                                y_d               = YMAX[COORD_W-1:0];
                                dir_y_d           = 1'b0;
                                hit_d[HitBottom]  = 1'b1;
                            end else begin
                                y_d = y_inc[COORD_W-1:0];
                            end
                        end else if (y_floor) begin
                            y_d            = '0;
                            dir_y_d        = 1'b1;
                            hit_d[HitTop]  = 1'b1;
                        end else begin
                            y_d = y_dec;
                        end
                    end
                end

                ModeManual: begin
                    if (speed != 4'd0) begin
                        if (btn_right && !btn_left) begin
                            dir_x_d = 1'b1;
                            if (x_inc >= XMAX) begin
                                x_d             = XMAX[COORD_W-1:0];
                                hit_d[HitRight] = 1'b1;
                            end else begin
                                x_d = x_inc[COORD_W-1:0];
                            end
                        end else if (btn_left && !btn_right) begin
                            dir_x_d = 1'b0;
                            if (x_floor) begin
                                x_d            = '0;
                                hit_d[HitLeft] = 1'b1;
                            end else begin
                                x_d = x_dec;
                            end
                        end

                        if (btn_down && !btn_up) begin
                            dir_y_d = 1'b1;
                            if (y_inc >= YMAX) begin
                                y_d              = YMAX[COORD_W-1:0];
                                hit_d[HitBottom] = 1'b1;
                            end else begin
                                y_d = y_inc[COORD_W-1:0];
                            end
                        end else if (btn_up && !btn_down) begin
                            dir_y_d = 1'b0;
                            if (y_floor) begin
                                y_d           = '0;
                                hit_d[HitTop] = 1'b1;
                            end else begin
                                y_d = y_dec;
                            end
                        end
                    end
                end

                ModeHold: begin
                end

                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= XSTART;
            y_q     <= YSTART;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            der_q   <= XSTART + WM1;
            down_q  <= YSTART + HM1;
            hit_q   <= 4'b0000;
            wrap_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            der_q   <= x_d + WM1;
            down_q  <= y_d + HM1;
            hit_q   <= hit_d;
            wrap_q  <= wrap_d;
        end
    end

    assign borde_izq  = x_q;
    assign borde_der  = der_q;
    assign borde_up   = y_q;
    assign borde_down = down_q;
    assign edge_hit   = hit_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_rect_mover.sv
// Self-checking bench for rect_mover with default parameters.
// Expected output vectors {izq,der,up,down,edge_hit,wrap} are queued as each
// step is driven and popped/compared once the DUT has registered the update.
module tb_rect_mover;

    localparam int XMAX = 540;
    localparam int YMAX = 430;
    localparam int W    = 100;
    localparam int H    = 50;

    localparam logic [1:0] RASTER = 2'b00;
    localparam logic [1:0] BOUNCE = 2'b01;
    localparam logic [1:0] MANUAL = 2'b10;
    localparam logic [1:0] HOLD   = 2'b11;

    // btn encoding {left,right,up,down}; hit encoding {top,bottom,left,right}
    typedef struct {
        bit         tk;
        bit         rs;
        bit         mv;
        logic [1:0] md;
        logic [3:0] sp;
        logic [3:0] btn;
        int         x;
        int         y;
        logic [3:0] hit;
        logic       wr;
    } step_t;

    logic        clk = 1'b0;
    logic        rst, frame_tick, move;
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic        btn_left, btn_right, btn_up, btn_down;
    logic [11:0] borde_izq, borde_der, borde_up, borde_down;
    logic [3:0]  edge_hit;
    logic        wrap;

    int vectors     = 0;
    int miscompares = 0;

    logic [52:0] sb[$];
    int          mx, my;    // expected rectangle position tracked by the bench

    always #5 clk = ~clk;

    rect_mover dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .move       (move),
        .mode       (mode),
        .speed      (speed),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .borde_izq  (borde_izq),
        .borde_der  (borde_der),
        .borde_up   (borde_up),
        .borde_down (borde_down),
        .edge_hit   (edge_hit),
        .wrap       (wrap)
    );

    wire [52:0] obs = {borde_izq, borde_der, borde_up, borde_down, edge_hit, wrap};

    function automatic logic [52:0] pack(input int x, input int y, input logic [3:0] hit,
                                         input logic wr);
        logic [11:0] a, b, c, d;
        a = 12'(x);
        b = 12'(x + W - 1);
        c = 12'(y);
        d = 12'(y + H - 1);
        return {a, b, c, d, hit, wr};
    endfunction

    function automatic step_t mk(input bit tk, input bit rs, input bit mv, input logic [1:0] md,
                                 input logic [3:0] sp, input logic [3:0] btn, input int x,
                                 input int y, input logic [3:0] hit, input logic wr);
        step_t s;
        s.tk = tk; s.rs = rs; s.mv = mv; s.md = md; s.sp = sp; s.btn = btn;
        s.x = x; s.y = y; s.hit = hit; s.wr = wr;
        return s;
    endfunction

    // Queue the expectation, then either pulse frame_tick or let one idle cycle pass.
    task automatic apply(input step_t s);
        sb.push_back(pack(s.x, s.y, s.hit, s.wr));
        @(negedge clk);
        if (s.tk) begin
            mode  = s.md;
            speed = s.sp;
            {btn_left, btn_right, btn_up, btn_down} = s.btn;
            move       = s.mv;
            rst        = s.rs;
            frame_tick = 1'b1;
        end
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        rst        = 1'b0;
        move       = 1'b0;
        {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    endtask

    // Steer to (tx,ty) in MANUAL mode, x axis first, checking every step.
    task automatic goto(input int tx, input int ty);
        step_t       s;
        int          sp;
        logic [3:0]  btn, hit;
        logic [52:0] exp_v;
        for (int i = 0; i < 200 && (mx != tx || my != ty); i++) begin
            btn = 4'b0000;
            hit = 4'b0000;
            if (mx != tx) begin
                sp = (tx > mx) ? tx - mx : mx - tx;
                if (sp > 15) sp = 15;
                if (tx > mx) begin
                    btn = 4'b0100; mx = mx + sp; if (mx == XMAX) hit[0] = 1'b1;
                end else begin
                    btn = 4'b1000; mx = mx - sp; if (mx == 0) hit[1] = 1'b1;
                end
            end else begin
                sp = (ty > my) ? ty - my : my - ty;
                if (sp > 15) sp = 15;
                if (ty > my) begin
                    btn = 4'b0001; my = my + sp; if (my == YMAX) hit[2] = 1'b1;
                end else begin
                    btn = 4'b0010; my = my - sp; if (my == 0) hit[3] = 1'b1;
                end
            end
            s = mk(1, 0, 1, MANUAL, 4'(sp), btn, mx, my, hit, 1'b0);
            apply(s);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL goto(%0d,%0d) step %0d: got %h want %h", tx, ty, i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        step_t       s;
        logic [52:0] exp_v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                sb.push_back(pack(0, 100, 4'b0000, 1'b0));
            end else begin
                s = mk(1, 0, 0, RASTER, 4'd4, 4'b0000, 0, 100, 4'b0000, 1'b0);
                apply(s);
            end
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset/no_move %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 0;
        my = 100;
    endtask

    task automatic test_raster();
        step_t       q[$];
        logic [52:0] exp_v;
        goto(536, 428);
        q.push_back(mk(1, 0, 1, RASTER, 4'd4, 4'b0000, 540, 428, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, RASTER, 4'd4, 4'b0000, 0, 100, 4'b0000, 1'b1));
        q.push_back(mk(0, 0, 0, RASTER, 4'd0, 4'b0000, 0, 100, 4'b0000, 1'b0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL raster frame %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 0;
        my = 100;
        q.delete();
        goto(538, 100);
        q.push_back(mk(1, 0, 1, RASTER, 4'd4, 4'b0000, 0, 104, 4'b0000, 1'b1));
        q.push_back(mk(0, 0, 0, RASTER, 4'd0, 4'b0000, 0, 104, 4'b0000, 1'b0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL raster line %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 0;
        my = 104;
    endtask

    task automatic test_bounce();
        step_t       q[$];
        logic [52:0] exp_v;
        goto(538, 200);   // last moves right then down: dir_x = dir_y = 1
        q.push_back(mk(1, 0, 1, BOUNCE, 4'd4, 4'b0000, 540, 204, 4'b0001, 1'b0));
        q.push_back(mk(0, 0, 0, BOUNCE, 4'd0, 4'b0000, 540, 204, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, BOUNCE, 4'd4, 4'b0000, 536, 208, 4'b0000, 1'b0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL bounce right %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 536;
        my = 208;
        q.delete();
        goto(1, 2);       // last moves left then up: dir_x = dir_y = 0
        q.push_back(mk(1, 0, 1, BOUNCE, 4'd5, 4'b0000, 0, 0, 4'b1010, 1'b0));
        q.push_back(mk(1, 0, 1, BOUNCE, 4'd5, 4'b0000, 5, 5, 4'b0000, 1'b0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL bounce corner %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 5;
        my = 5;
    endtask

    task automatic test_manual();
        step_t       q[$];
        logic [52:0] exp_v;
        goto(2, 5);
        q.push_back(mk(1, 0, 1, MANUAL, 4'd4, 4'b1000, 0, 5, 4'b0010, 1'b0));
        q.push_back(mk(0, 0, 0, MANUAL, 4'd0, 4'b0000, 0, 5, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, MANUAL, 4'd4, 4'b1100, 0, 5, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, MANUAL, 4'd4, 4'b0101, 4, 9, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, HOLD,   4'd4, 4'b0101, 4, 9, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, MANUAL, 4'd0, 4'b0101, 4, 9, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, MANUAL, 4'd3, 4'b0011, 4, 9, 4'b0000, 1'b0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL manual %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 4;
        my = 9;
    endtask

    task automatic test_reset_on_tick();
        step_t       q[$];
        logic [52:0] exp_v;
        goto(300, 9);     // dir_y still 1 from the earlier down press
        q.push_back(mk(1, 0, 1, BOUNCE, 4'd3, 4'b0000, 303, 12, 4'b0000, 1'b0));
        q.push_back(mk(1, 1, 1, BOUNCE, 4'd15, 4'b0000, 0, 100, 4'b0000, 1'b0));
        q.push_back(mk(1, 0, 1, BOUNCE, 4'd3, 4'b0000, 3, 103, 4'b0000, 1'b0));
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i]);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL rst_with_tick %0d: got %h want %h", i, obs, exp_v);
            end
        end
        mx = 3;
        my = 103;
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        move       = 1'b0;
        mode       = RASTER;
        speed      = 4'd0;
        {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
        mx = 0;
        my = 100;

        test_reset();
        test_raster();
        test_bounce();
        test_manual();
        test_reset_on_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
